// File: rtl/alu_core_if.sv
// Operand/result bundle for alu_core. The master drives a, b and opn.
// The slave returns the registered results and the flags.
interface alu_core_if;
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] opn;
    logic [3:0] alu_out0;
    logic [3:0] alu_out1;
    logic [3:0] status;

    modport master (
        output a,
        output b,
        output opn,
        input  alu_out0,
        input  alu_out1,
        input  status
    );

    modport slave (
        input  a,
        input  b,
        input  opn,
        output alu_out0,
        output alu_out1,
        output status
    );
endinterface

// File: rtl/alu_core.sv
// 4-bit registered ALU with one cycle of latency. It has no handshake, so every edge starts a new operation.
// Optional macro ALU_DIV_EN enables the opn=3 divider. Without it, opn=3 reports an unsupported op (V=1, Z=1).
module alu_core (
    input  logic        clk,
    input  logic        rst,
    alu_core_if.slave   bus
);
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_AND = 3'd4;
    localparam logic [2:0] OP_OR  = 3'd5;
    localparam logic [2:0] OP_XOR = 3'd6;
    localparam logic [2:0] OP_SHL = 3'd7;

    logic [3:0] out0_q, out0_d;
    logic [3:0] out1_q, out1_d;
    logic [3:0] status_q, status_d;

    logic [4:0] sum_w;
    logic [4:0] diff_w;
    logic [7:0] prod_w;
    logic [7:0] shl_w;

    assign sum_w  = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff_w = {1'b0, bus.a} - {1'b0, bus.b};
    assign prod_w = {4'b0, bus.a} * {4'b0, bus.b};
    assign shl_w  = {4'b0, bus.a} << bus.b[2:0];

`ifdef ALU_DIV_EN
    // Restoring divider: one compare/subtract stage for each quotient bit, starting at the MSB.
    logic [4:0] rem_w [0:4];
    logic [3:0] quo_w;

    assign rem_w[0] = 5'd0;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_div_stage
            logic [4:0] trial_w;
            logic       ge_w;
            assign trial_w = {rem_w[gi][3:0], bus.a[3-gi]};
            assign ge_w    = (trial_w >= {1'b0, bus.b});
            assign quo_w[3-gi] = ge_w;
            assign rem_w[gi+1] = ge_w ? (trial_w - {1'b0, bus.b}) : trial_w;
        end
    endgenerate
`endif

    always_comb begin
        logic c_flag;
        logic v_flag;
        logic force_status;
        out0_d       = 4'h0;
        out1_d       = 4'h0;
        c_flag       = 1'b0;
        v_flag       = 1'b0;
        force_status = 1'b0;
        status_d     = 4'h0;

        case (bus.opn)
            OP_ADD: begin
                out0_d = sum_w[3:0];
                out1_d = {3'b0, sum_w[4]};
                c_flag = sum_w[4];
                v_flag = (bus.a[3] == bus.b[3]) && (sum_w[3] != bus.a[3]);
            end
            OP_SUB: begin
                out0_d = diff_w[3:0];
                out1_d = {3'b0, diff_w[4]};
                c_flag = diff_w[4];
                v_flag = (bus.a[3] != bus.b[3]) && (diff_w[3] != bus.a[3]);
            end
            OP_MUL: begin
                out0_d = prod_w[3:0];
                out1_d = prod_w[7:4];
                c_flag = (prod_w[7:4] != 4'h0);
            end
            OP_DIV: begin
`ifdef ALU_DIV_EN
                if (bus.b == 4'h0) begin
                    out0_d = 4'hF;
                    out1_d = bus.a;
                    v_flag = 1'b1;
                end else begin
                    out0_d = quo_w;
                    out1_d = rem_w[4][3:0];
                end
`else
                force_status = 1'b1;
`endif
            end
            OP_AND: out0_d = bus.a & bus.b;
            OP_OR:  out0_d = bus.a | bus.b;
            OP_XOR: out0_d = bus.a ^ bus.b;
            OP_SHL: begin
                out0_d = shl_w[3:0];
                out1_d = shl_w[7:4];
                c_flag = (shl_w[7:4] != 4'h0);
            end
            default: ;
        endcase

        if (force_status) begin
            status_d = 4'b1001;
        end else begin
            status_d = {v_flag, out0_d[3], c_flag, (out0_d == 4'h0)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out0_q   <= 4'h0;
            out1_q   <= 4'h0;
            status_q <= 4'h0;
        end else begin
            out0_q   <= out0_d;
            out1_q   <= out1_d;
            status_q <= status_d;
        end
    end

    assign bus.alu_out0 = out0_q;
    assign bus.alu_out1 = out1_q;
    assign bus.status   = status_q;
endmodule

// File: tb/tb_alu_core.sv
// Directed bench for alu_core. Each step drives one operation and checks the results one edge later.
module tb_alu_core;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    alu_core_if bus ();

    alu_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step(input string tag, input logic r, input logic [3:0] av,
                        input logic [3:0] bv, input logic [2:0] op,
                        input logic [3:0] e0, input logic [3:0] e1, input logic [3:0] es);
        @(negedge clk);
        rst     = r;
        bus.a   = av;
        bus.b   = bv;
        bus.opn = op;
        @(posedge clk);
        #1;
        $display("step %-10s rst=%0b a=%h b=%h opn=%0d -> out0=%h out1=%h status=%b",
                 tag, r, av, bv, op, bus.alu_out0, bus.alu_out1, bus.status);
        vectors++;
        assert (bus.alu_out0 === e0) else begin
            miscompares++;
            $error("FAIL %s out0: got %h expected %h", tag, bus.alu_out0, e0);
        end
        vectors++;
        assert (bus.alu_out1 === e1) else begin
            miscompares++;
            $error("FAIL %s out1: got %h expected %h", tag, bus.alu_out1, e1);
        end
        vectors++;
        assert (bus.status === es) else begin
            miscompares++;
            $error("FAIL %s status: got %b expected %b", tag, bus.status, es);
        end
    endtask

    initial begin
        bus.a   = 4'h0;
        bus.b   = 4'h0;
        bus.opn = 3'd0;

        step("rst0",     1'b1, 4'h0, 4'h0, 3'd0, 4'h0, 4'h0, 4'b0000);
        step("rst1",     1'b1, 4'h0, 4'h0, 3'd0, 4'h0, 4'h0, 4'b0000);
        step("rsthold",  1'b1, 4'h5, 4'h5, 3'd0, 4'h0, 4'h0, 4'b0000);
        step("add37",    1'b0, 4'h3, 4'h7, 3'd0, 4'hA, 4'h0, 4'b1100);
        step("addwrap",  1'b0, 4'hF, 4'h1, 3'd0, 4'h0, 4'h1, 4'b0011);
        step("addovf",   1'b0, 4'h8, 4'h8, 3'd0, 4'h0, 4'h1, 4'b1011);
        step("sub01",    1'b0, 4'h0, 4'h1, 3'd1, 4'hF, 4'h1, 4'b0110);
        step("subovf",   1'b0, 4'h8, 4'h1, 3'd1, 4'h7, 4'h0, 4'b1000);
        step("mulff",    1'b0, 4'hF, 4'hF, 3'd2, 4'h1, 4'hE, 4'b0010);
        step("mulzero",  1'b0, 4'h0, 4'h9, 3'd2, 4'h0, 4'h0, 4'b0001);
        step("shl93",    1'b0, 4'h9, 4'h3, 3'd7, 4'h8, 4'h4, 4'b0110);
        step("shlb3ign", 1'b0, 4'h1, 4'h8, 3'd7, 4'h1, 4'h0, 4'b0000);
        step("shlf7",    1'b0, 4'hF, 4'h7, 3'd7, 4'h0, 4'h8, 4'b0011);
`ifdef ALU_DIV_EN
        step("div134",   1'b0, 4'hD, 4'h4, 3'd3, 4'h3, 4'h1, 4'b0000);
        step("div90",    1'b0, 4'h9, 4'h0, 3'd3, 4'hF, 4'h9, 4'b1100);
        step("divff",    1'b0, 4'hF, 4'h1, 3'd3, 4'hF, 4'h0, 4'b0100);
`else
        step("divoff",   1'b0, 4'hD, 4'h4, 3'd3, 4'h0, 4'h0, 4'b1001);
        step("divoff0",  1'b0, 4'h9, 4'h0, 3'd3, 4'h0, 4'h0, 4'b1001);
`endif
        step("and",      1'b0, 4'hC, 4'hA, 3'd4, 4'h8, 4'h0, 4'b0100);
        step("or",       1'b0, 4'hC, 4'hA, 3'd5, 4'hE, 4'h0, 4'b0100);
        step("xor",      1'b0, 4'hC, 4'hA, 3'd6, 4'h6, 4'h0, 4'b0000);
        step("and2",     1'b0, 4'hC, 4'hA, 3'd4, 4'h8, 4'h0, 4'b0100);
        step("midrst",   1'b1, 4'hC, 4'hA, 3'd5, 4'h0, 4'h0, 4'b0000);
        step("xorpost",  1'b0, 4'hC, 4'hA, 3'd6, 4'h6, 4'h0, 4'b0000);
        step("repeat",   1'b0, 4'hC, 4'hA, 3'd6, 4'h6, 4'h0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
